// File: rtl/service_protocol_unpacker_buf.sv
// Service-protocol unpacker that holds packet payload until its checksum checks out, then releases it downstream.
// Define SPU_TIMEOUT_EN to abort a packet after TIMEOUT idle cycles mid-packet.
module service_protocol_unpacker_buf #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_request,
  output logic [WIDTH-1:0] out_data,
  output logic             out_request,
  input  logic             out_done,
  output logic [7:0]       cmd,
  output logic             pkt_ok,
  output logic             err_csum,
  output logic             err_ovf,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH - 8;
  localparam int CW = (SW > AW + 1) ? SW + 1 : AW + 2;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [SW:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SIZE, S_DATA, S_CSUM, S_SKIPHDR, S_SKIP
  } state_e;

  state_e           state_q, state_d;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d, commit_q, commit_d;
  logic [SW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [7:0]       cmd_q, cmd_d, cmd_lat_q, cmd_lat_d;
  logic             pkt_ok_q, pkt_ok_d, err_csum_q, err_csum_d, err_ovf_q, err_ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [SW-1:0]    size_w;
  logic [AW:0]      used_w;
  logic [CW-1:0]    free_w;
  logic             xfer;

  assign size_w = in_data[WIDTH-1:8];
  assign used_w = wr_q - rd_q;
  assign free_w = CW'(DEPTH) - CW'(used_w);

  // Only committed words are visible; the read side never sees a packet still being checked.
  assign out_request = (rd_q != commit_q);
  assign out_data    = out_request ? mem_q[rd_q[AW-1:0]] : '0;
  assign xfer        = out_request && out_done;

  assign cmd      = cmd_q;
  assign pkt_ok   = pkt_ok_q;
  assign err_csum = err_csum_q;
  assign err_ovf  = err_ovf_q;
  assign busy     = (state_q != S_IDLE);

`ifdef SPU_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_ONE = 1;
  logic [GW-1:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    commit_d   = commit_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    cmd_d      = cmd_q;
    cmd_lat_d  = cmd_lat_q;
    pkt_ok_d   = 1'b0;
    err_csum_d = 1'b0;
    err_ovf_d  = 1'b0;
    wr_en      = 1'b0;
    rd_d       = xfer ? rd_q + PTR_ONE : rd_q;

    if (in_request) begin
      case (state_q)
        S_IDLE: begin
          sum_d   = in_data;
          state_d = (in_data[WIDTH-1 -: 8] == addr) ? S_SIZE : S_SKIPHDR;
        end
        S_SIZE: begin
          sum_d     = sum_q + in_data;
          cmd_lat_d = in_data[7:0];
          if (CW'(size_w) > free_w) begin
            err_ovf_d = 1'b1;
            cnt_d     = {1'b0, size_w} + CNT_ONE;
            state_d   = S_SKIP;
          end else if (size_w == '0) begin
            state_d = S_CSUM;
          end else begin
            cnt_d   = {1'b0, size_w};
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wr_en = 1'b1;
          wr_d  = wr_q + PTR_ONE;
          sum_d = sum_q + in_data;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (in_data == sum_q) begin
            commit_d = wr_q;
            cmd_d    = cmd_lat_q;
            pkt_ok_d = 1'b1;
          end else begin
            wr_d       = commit_q;
            err_csum_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        S_SKIPHDR: begin
          cnt_d   = {1'b0, size_w} + CNT_ONE;
          state_d = S_SKIP;
        end
        S_SKIP: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef SPU_TIMEOUT_EN
    gap_d = gap_q;
    if (in_request) begin
      gap_d = '0;
    end else if (state_q != S_IDLE) begin
      if (gap_q == GW'(TIMEOUT - 1)) begin
        // A stalled sender abandons the packet exactly like a bad checksum.
        gap_d      = '0;
        wr_d       = commit_q;
        err_csum_d = 1'b1;
        state_d    = S_IDLE;
      end else begin
        gap_d = gap_q + GAP_ONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      commit_q   <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cmd_q      <= '0;
      cmd_lat_q  <= '0;
      pkt_ok_q   <= 1'b0;
      err_csum_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      commit_q   <= commit_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cmd_q      <= cmd_d;
      cmd_lat_q  <= cmd_lat_d;
      pkt_ok_q   <= pkt_ok_d;
      err_csum_q <= err_csum_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

`ifdef SPU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_service_protocol_unpacker_buf.sv
// Randomized bench for service_protocol_unpacker_buf against a packet-level reference model.
// Handshake: a payload word moves on a cycle where out_request && out_done are both high.
module tb_service_protocol_unpacker_buf;
  localparam int W = 16;
  localparam int D = 32;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   addr;
  logic [W-1:0] in_data;
  logic         in_request;
  logic [W-1:0] out_data;
  logic         out_request;
  logic         out_done;
  logic [7:0]   cmd;
  logic         pkt_ok, err_csum, err_ovf, busy;

  service_protocol_unpacker_buf #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .addr(addr), .in_data(in_data), .in_request(in_request),
    .out_data(out_data), .out_request(out_request), .out_done(out_done), .cmd(cmd),
    .pkt_ok(pkt_ok), .err_csum(err_csum), .err_ovf(err_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ptmp[$];
  logic         exp_ok, exp_csum, exp_ovf, exp_busy;
  logic [7:0]   exp_cmd, pcmd;
  logic [W-1:0] psum;
  int           pos, psize, pend_pre, gap, done_mode, gap_max;
  bit           pmatch, paccept;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    ptmp.delete();
    exp_ok = 0; exp_csum = 0; exp_ovf = 0; exp_busy = 0; exp_cmd = 8'h00;
    pos = 0; gap = 0;
  endtask

  // One cycle: check what the DUT shows, then choose out_done and retire a transfer.
  task automatic tick();
    @(negedge clk);
    chk("pkt_ok", 32'(pkt_ok), 32'(exp_ok));
    chk("err_csum", 32'(err_csum), 32'(exp_csum));
    chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("cmd", 32'(cmd), 32'(exp_cmd));
    chk("out_request", 32'(out_request), 32'(exp_q.size() != 0));
    exp_ok = 0; exp_csum = 0; exp_ovf = 0;
    case (done_mode)
      0:       out_done = 1'b1;
      1:       out_done = 1'b0;
      default: out_done = 1'($urandom_range(0, 1));
    endcase
    pend_pre = exp_q.size();
    if (exp_q.size() != 0 && out_done) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
  endtask

  task automatic idle();
    tick();
    in_request = 1'b0;
    in_data    = W'($urandom);
`ifdef SPU_TIMEOUT_EN
    if (exp_busy) begin
      gap++;
      if (gap == T) begin
        exp_csum = 1; exp_busy = 0; gap = 0; pos = 0; ptmp.delete();
      end
    end
`endif
  endtask

  task automatic push(input logic [W-1:0] w);
    tick();
    in_request = 1'b1;
    in_data    = w;
    gap        = 0;
    if (pos == 0) begin
      psum = w; pmatch = (w[15:8] == addr); exp_busy = 1; pos = 1;
    end else if (pos == 1) begin
      psize = int'(w[15:8]); pcmd = w[7:0]; psum = psum + w;
      paccept = pmatch && (psize <= D - pend_pre);
      if (pmatch && !paccept) exp_ovf = 1;
      ptmp.delete(); pos = 2;
    end else if (pos < psize + 2) begin
      psum = psum + w;
      if (paccept) ptmp.push_back(w);
      pos++;
    end else begin
      if (paccept) begin
        if (w == psum) begin
          exp_ok = 1; exp_cmd = pcmd;
          foreach (ptmp[i]) exp_q.push_back(ptmp[i]);
        end else begin
          exp_csum = 1;
        end
      end
      exp_busy = 0; pos = 0;
    end
  endtask

  task automatic push_pkt(input logic [7:0] a, input int size, input logic [7:0] c, input bit bad);
    logic [W-1:0] words[$];
    logic [W-1:0] s;
    words.push_back({a, 8'($urandom)});
    words.push_back({8'(size), c});
    for (int i = 0; i < size; i++) words.push_back(W'($urandom));
    s = '0;
    foreach (words[i]) s = s + words[i];
    words.push_back(bad ? s + W'($urandom_range(1, 255)) : s);
    foreach (words[i]) begin
      repeat ($urandom_range(0, gap_max)) idle();
      push(words[i]);
    end
  endtask

  task automatic drain();
    int budget = 400;
    while ((exp_q.size() != 0 || exp_busy) && budget > 0) begin
      idle();
      budget--;
    end
    chk("drain_budget", 32'(budget != 0), 32'(1));
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_request = 1'b0; out_done = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = 8'hAB; in_data = '0; in_request = 1'b0; out_done = 1'b0;
    done_mode = 0; gap_max = 0;
    model_clear();
    do_reset();
    @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_request", 32'(out_request), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_pulses", 32'({pkt_ok, err_csum, err_ovf}), 32'(0));

    // Directed good packet, then the same with a bad checksum
    push(16'hAB00); push(16'h02A2); push(16'hEFAB); push(16'h0001); push(16'h9D4E);
    repeat (4) idle();
    chk("cmd_A2", 32'(cmd), 32'h00A2);
    push(16'hAB00); push(16'h02A2); push(16'hEFAB); push(16'h0001); push(16'h9D4F);
    repeat (3) idle();
    chk("bad_no_req", 32'(out_request), 32'(0));

    // Address mismatch skipped, following local packet commits
    addr = 8'h12;
    push(16'hAB00); push(16'h02A2); push(16'hEFAB); push(16'h0001); push(16'h9D4E);
    push_pkt(8'h12, 3, 8'h55, 0);
    drain();

    // Oversize header: 33 payload words + checksum skipped
    push_pkt(8'h12, 33, 8'h66, 0);
    push_pkt(8'h12, 1, 8'h77, 0);
    drain();

    // Backpressure: two packets held, third too big for remaining space
    done_mode = 1;
    push_pkt(8'h12, 2, 8'h01, 0);
    push_pkt(8'h12, 2, 8'h02, 0);
    push_pkt(8'h12, 29, 8'h03, 0);
    repeat (3) idle();
    chk("held_words", 32'(out_request), 32'(1));
    push_pkt(8'h12, 28, 8'h04, 0);
    done_mode = 0;
    drain();

    // Reset in the middle of a packet with committed words pending
    done_mode = 1;
    push_pkt(8'h12, 3, 8'h21, 0);
    push(16'h1200); push(16'h0422); push(16'h5555);
    do_reset();
    done_mode = 2;
    push_pkt(8'h12, 2, 8'h22, 0);
    drain();

`ifdef SPU_TIMEOUT_EN
    push(16'h1200); push(16'h0233);
    repeat (T + 3) idle();
    chk("timeout_busy", 32'(busy), 32'(0));
    push_pkt(8'h12, 2, 8'h34, 0);
    drain();
`endif

    // Randomized traffic
    gap_max = 2;
    for (int n = 0; n < 80; n++) begin
      int sz;
      logic [7:0] a;
      done_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      addr = 8'($urandom);
      a = ($urandom_range(0, 3) != 0) ? addr : 8'($urandom);
      sz = ($urandom_range(0, 5) == 0) ? $urandom_range(0, D + 2) : $urandom_range(0, 6);
      push_pkt(a, sz, 8'($urandom), $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    done_mode = 2;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/service_protocol_unpacker_buf.md
Name: service_protocol_unpacker_buf

Overview:
- Parametrised successor to the service-protocol unpacker. Consumes the word stream pushed by spiReceiver, parses service packets and checks the per-packet checksum.
- Payload words are buffered and only released to the downstream Mil-1553 encoder push path after the checksum passes. Failed packets are discarded atomically.
- Adds generic word width, payload depth, address filtering, an output ready handshake and error reporting.

Parameters:
- WIDTH, 16, word width. Must be >= 16. Header fields sit in the top/bottom bytes as defined below.
- DEPTH, 32, payload buffer depth in words. Power of 2. This is also the maximum accepted packet size.
- TIMEOUT, 1024, inter-word gap limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr  in  8  local module address, sampled when a header word arrives
- in_data  in  WIDTH  pushed word from spiReceiver
- in_request  in  1  push strobe: one word per high cycle, no backpressure
- out_data  out  WIDTH  payload word to Mil encoder
- out_request  out  1  out_data valid
- out_done  in  1  downstream ready; a word transfers when out_request && out_done
- cmd  out  8  command byte of the last committed packet
- pkt_ok  out  1  1-cycle pulse when a packet commits
- err_csum  out  1  1-cycle pulse on checksum mismatch
- err_ovf  out  1  1-cycle pulse when a packet is rejected for size
- busy  out  1  high while the parser is not in IDLE

Behaviour:
- Packet format:
  - w0: address in bits [WIDTH-1:WIDTH-8]; remaining bits ignored.
  - w1: size in bits [WIDTH-1:8], cmd in bits [7:0].
  - Then `size` payload words.
  - Then the checksum word, equal to the sum mod 2^WIDTH of w0, w1 and every payload word.
- Reset: all outputs 0, FSM to IDLE, buffer empty (rd=wr=commit=0), running sum 0.
- Parser FSM. Each transition occurs on a cycle with in_request=1; states hold otherwise.
  - IDLE: the received word starts a new sum. If the address matches, go to SIZE; otherwise go to SKIPHDR.
  - SIZE: latch size and cmd, add the word to the sum.
    - If size > free space, pulse err_ovf and go to SKIP with skip count = size+1.
    - Else if size == 0, go to CSUM.
    - Else go to DATA.
  - DATA: write the word to buf[wr], wr++, add it to the sum, count down. On the last payload word go to CSUM.
  - CSUM:
    - If the word equals the sum: commit=wr, cmd register updated, pulse pkt_ok.
    - Else: wr=commit (rollback), pulse err_csum.
    - Either way go to IDLE.
  - SKIPHDR: read size from bits [WIDTH-1:8], load skip count = size+1, go to SKIP.
  - SKIP: decrement the count; go to IDLE when it reaches 0. No pulses and no writes.
- Free space = DEPTH - (wr - rd), with pointers one bit wider than log2(DEPTH) for full/empty detection. Only committed words are visible to the read side.
- Output side:
  - out_request = (rd != commit). out_data = buf[rd] combinationally from a registered rd.
  - Each transfer increments rd.
  - Reading and writing in the same cycle are legal and independent.
- Latency: the first payload word of a packet is presented 1 cycle after the checksum word is accepted.
- Simultaneous events: a commit and an output transfer in the same cycle both take effect. Free space for the next header uses the post-update pointers.
- rst mid-packet: buffered words, including committed ones, are dropped and the FSM goes to IDLE.
- Pointer wrap-around is natural modulo 2·DEPTH; no special handling.

Optional Feature:
- Macro: SPU_TIMEOUT_EN.
- With the macro defined:
  - A gap counter clears on every in_request and increments while busy.
  - Reaching TIMEOUT forces a rollback (wr=commit), pulses err_csum and returns the FSM to IDLE.
- Without the macro: no counter; the parser waits indefinitely.

Test Plan:
- Good packet, addr=8'hAB: push AB00, 02A2, EFAB, 0001, 9D4E with out_done=1.
  - Required: pkt_ok pulse, cmd=A2, then out_data EFAB then 0001; no errors.
- Same packet with checksum 9D4F.
  - Required: err_csum pulse, no out_request, buffer pointers restored.
- Address mismatch: addr=8'h12, push the packet above followed by a good packet for address 12.
  - Required: the first packet is silently skipped; the second commits.
- Oversize, DEPTH=32: header size=33.
  - Required: err_ovf pulse; the next 34 words are skipped; a following good packet commits.
- Backpressure: out_done=0 while two 2-word packets commit.
  - Required: 4 words are held; releasing out_done yields them in order. A third packet with size > remaining free space raises err_ovf.
- SPU_TIMEOUT_EN with TIMEOUT=16: stop after the header.
  - Required: err_csum after 16 idle cycles; busy drops; the next packet parses normally.
